mod7_preimage_enum: RTL and testbench

// - Inverse of the 4-bit residue logic (F1F2F3 = {a,b,c,d} mod 7).
// - Accepts a residue code r on a valid/ready request port.
// - Streams, in ascending order, every WIDTH-bit value n where n mod MOD == r.
// - One value per accepted output beat.
// - Used by the self-check bench and by table-free reverse lookup next to the residue block.

---
 rtl/mod7_preimage_enum.sv | 71 +++++++
 tb/tb_mod7_preimage_enum.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mod7_preimage_enum.sv
// mod7_preimage_enum: streams every WIDTH-bit n with n mod MOD == r, ascending, one per beat.
module mod7_preimage_enum #(
    parameter int WIDTH = 4,
    parameter int MOD   = 7,
    parameter int RW    = $clog2(MOD + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [RW-1:0]    req_residue,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_err,
    output logic [WIDTH-1:0] out_index
);
    typedef enum logic [1:0] {IDLE, EMIT, ERR} state_t;
    state_t state;
    localparam logic [WIDTH:0] MAXV = (WIDTH + 1)'(2 ** WIDTH - 1);
    localparam logic [WIDTH:0] STEP = (WIDTH + 1)'(MOD);
    logic [WIDTH-1:0] start, next;
    logic legal;
    assign start = WIDTH'(req_residue);
    assign next  = out_data + WIDTH'(MOD);
    assign legal = req_residue < RW'(MOD);
    // Widened sum so the final value never wraps back into range.
    function automatic logic is_last(input logic [WIDTH-1:0] v);
        return ({1'b0, v} + STEP) > MAXV;
    endfunction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
            out_index <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid && req_ready) begin
                    state     <= legal ? EMIT : ERR;
                    req_ready <= 1'b0;
                    out_valid <= 1'b1;
                    out_data  <= legal ? start : '0;
                    out_last  <= legal ? is_last(start) : 1'b1;
                    out_err   <= !legal;
                    out_index <= '0;
                end
                EMIT, ERR: if (out_ready) begin
                    if (out_last) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        out_last  <= 1'b0;
                        out_err   <= 1'b0;
                        out_index <= '0;
                    end else begin
                        out_data  <= next;
                        out_index <= out_index + 1'b1;
                        out_last  <= is_last(next);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mod7_preimage_enum.sv
// tb_mod7_preimage_enum: scoreboard bench for the mod-7 preimage enumerator.
module tb_mod7_preimage_enum;
    logic clk = 1'b0;
    logic rst, req_valid, req_ready, out_valid, out_ready, out_last, out_err;
    logic [2:0] req_residue;
    logic [3:0] out_data, out_index;
    typedef struct packed {
        logic [3:0] data;
        logic       last;
        logic       err;
        logic [3:0] index;
    } beat_t;
    beat_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    mod7_preimage_enum dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_residue(req_residue), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .out_err(out_err), .out_index(out_index)
    );

    always #5 clk = ~clk;

    // Expected response built by brute-force search over all 4-bit values.
    task automatic push_model(input int r);
        beat_t b;
        int k = 0;
        if (r >= 7) begin
            b.data = 4'd0; b.last = 1'b1; b.err = 1'b1; b.index = 4'd0;
            sb.push_back(b);
        end else begin
            for (int n = 0; n < 16; n++) begin
                if (n % 7 == r) begin
                    b.data = 4'(n); b.last = (n + 7 > 15); b.err = 1'b0; b.index = 4'(k);
                    sb.push_back(b);
                    k++;
                end
            end
        end
    endtask

    task automatic send(input logic [2:0] r);
        @(negedge clk);
        req_valid = 1'b1;
        req_residue = r;
        @(negedge clk);
        req_valid = 1'b0;
        req_residue = 3'($urandom);
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b0; req_residue = 3'd0; out_ready = 1'b0;
        #1;
        vectors++;
        if ({req_ready, out_valid, out_data, out_last, out_err, out_index} !== {1'b1, 11'd0}) begin
            miscompares++;
            $display("FAIL reset: got rdy=%b v=%b d=%0d l=%b e=%b i=%0d want rdy=1 rest 0",
                     req_ready, out_valid, out_data, out_last, out_err, out_index);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_wrap(input logic [2:0] r);
        beat_t e;
        int cyc = 0;
        push_model(int'(r));
        send(r);
        out_ready = 1'b1;
        while (sb.size() > 0 && cyc < 20) begin
            vectors++;
            if (!out_valid) begin
                miscompares++;
                $display("FAIL stream r=%0d: out_valid got 0 want 1 (back-to-back)", r);
            end else begin
                e = sb.pop_front();
                if ({out_data, out_last, out_err, out_index} !== e) begin
                    miscompares++;
                    $display("FAIL stream r=%0d: got d=%0d l=%b e=%b i=%0d want d=%0d l=%b e=%b i=%0d",
                             r, out_data, out_last, out_err, out_index, e.data, e.last, e.err, e.index);
                end
                if (e.last && req_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ready_on_last: got %b want 0", req_ready);
                end
            end
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (sb.size() != 0 || req_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL after_last r=%0d: left=%0d rdy=%b v=%b want 0/1/0", r, sb.size(), req_ready, out_valid);
        end
        sb.delete();
    endtask

    task automatic test_stall;
        logic [4:0] pat = 5'b10100;
        beat_t e;
        int cyc = 0;
        push_model(6);
        send(3'd6);
        while (sb.size() > 0 && cyc < 20) begin
            out_ready = (cyc < 5) ? pat[cyc] : 1'b1;
            vectors++;
            if (!out_valid) begin
                miscompares++;
                $display("FAIL stall: out_valid dropped at cycle %0d", cyc);
            end else if (out_ready) begin
                e = sb.pop_front();
                if ({out_data, out_last, out_err, out_index} !== e) begin
                    miscompares++;
                    $display("FAIL stall_beat: got d=%0d l=%b i=%0d want d=%0d l=%b i=%0d",
                             out_data, out_last, out_index, e.data, e.last, e.index);
                end
            end else if ({out_data, out_last, out_err, out_index} !== sb[0]) begin
                miscompares++;
                $display("FAIL stall_hold: got d=%0d i=%0d want d=%0d i=%0d", out_data, out_index, sb[0].data, sb[0].index);
            end
            @(negedge clk);
            cyc++;
        end
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL stall_timeout: %0d beats missing", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_illegal;
        beat_t e;
        int cyc = 0;
        push_model(7);
        send(3'd7);
        out_ready = 1'b1;
        while (sb.size() > 0 && cyc < 10) begin
            if (out_valid) begin
                e = sb.pop_front();
                vectors++;
                if ({out_data, out_last, out_err, out_index} !== e) begin
                    miscompares++;
                    $display("FAIL illegal: got d=%0d l=%b e=%b i=%0d want d=0 l=1 e=1 i=0",
                             out_data, out_last, out_err, out_index);
                end
            end
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (sb.size() != 0 || out_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_end: left=%0d v=%b rdy=%b want 0/0/1", sb.size(), out_valid, req_ready);
        end
        sb.delete();
    endtask

    task automatic test_sweep;
        int counts[7] = '{3, 3, 2, 2, 2, 2, 2};
        beat_t e;
        for (int r = 0; r < 7; r++) begin
            int cyc = 0;
            int beats = 0;
            push_model(r);
            send(3'(r));
            while (sb.size() > 0 && cyc < 40) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    e = sb.pop_front();
                    beats++;
                    vectors++;
                    if ({out_data, out_last, out_err, out_index} !== e || int'(out_data) % 7 != r) begin
                        miscompares++;
                        $display("FAIL sweep r=%0d: got d=%0d l=%b i=%0d want d=%0d l=%b i=%0d",
                                 r, out_data, out_last, out_index, e.data, e.last, e.index);
                    end
                end
                @(negedge clk);
                cyc++;
            end
            vectors++;
            if (beats != counts[r] || sb.size() != 0) begin
                miscompares++;
                $display("FAIL sweep_count r=%0d: got %0d beats want %0d", r, beats, counts[r]);
            end
            sb.delete();
        end
    endtask

    task automatic test_reset_mid;
        send(3'd0);
        out_ready = 1'b1;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 4'd0) begin
            miscompares++;
            $display("FAIL mid_first: got v=%b d=%0d want v=1 d=0", out_valid, out_data);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if ({req_ready, out_valid, out_data, out_last, out_err, out_index} !== {1'b1, 11'd0}) begin
            miscompares++;
            $display("FAIL mid_reset: got rdy=%b v=%b d=%0d l=%b e=%b i=%0d want rdy=1 rest 0",
                     req_ready, out_valid, out_data, out_last, out_err, out_index);
        end
        @(negedge clk);
        rst = 1'b0;
        test_wrap(3'd2);
    endtask

    initial begin
        test_reset;
        test_wrap(3'd0);
        test_wrap(3'd1);
        test_stall;
        test_illegal;
        test_sweep;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
